bist_addr_seq: RTL and testbench

- Parametrised BIST address sequencer. Successor to the fixed up/down address counter.
- Walks a programmable address window [adr_lo, adr_hi] up or down, in one of three orders: linear, column-major, or address-complement pairs.
- Flags the terminal address and pass completion, so the BIST controller can chain March elements.
- Sits between the BIST controller and the memory address mux.

---
 rtl/bist_addr_seq_if.sv | 29 ++
 rtl/bist_addr_seq.sv | 128 ++++++++++++
 tb/tb_bist_addr_seq.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/bist_addr_seq_if.sv
// Control/status bundle between the BIST controller and the address sequencer.
interface bist_addr_seq_if #(
  parameter int unsigned ADR_SIZE = 8
);
  logic                pr_res_adr;
  logic                start;
  logic                enable;
  logic                up_down;
  logic [1:0]          mode;
  logic [ADR_SIZE-1:0] adr_lo;
  logic [ADR_SIZE-1:0] adr_hi;
  logic [ADR_SIZE-1:0] adress;
  logic                valid;
  logic                c_out;
  logic                done;
  logic                err;

  // BIST controller side
  modport master (
    output pr_res_adr, start, enable, up_down, mode, adr_lo, adr_hi,
    input  adress, valid, c_out, done, err
  );

  // Address sequencer side
  modport slave (
    input  pr_res_adr, start, enable, up_down, mode, adr_lo, adr_hi,
    output adress, valid, c_out, done, err
  );
endinterface

// File: rtl/bist_addr_seq.sv
// BIST address sequencer: walks [adr_lo, adr_hi] up or down in linear,
// column-major or address-complement order, flagging the last step and pass end.
module bist_addr_seq #(
  parameter int unsigned ADR_SIZE = 8,
  parameter int unsigned COL_BITS = 4
) (
  input  logic          clk,
  input  logic          rst_adr,
  bist_addr_seq_if.slave bus
);

  localparam int unsigned ROW_BITS = ADR_SIZE - COL_BITS;

  localparam logic [1:0] MODE_LIN = 2'b00;
  localparam logic [1:0] MODE_COL = 2'b01;
  localparam logic [1:0] MODE_CMP = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  typedef struct packed {
    logic                up_down;
    logic [1:0]          mode;
    logic [ADR_SIZE-1:0] lo;
    logic [ADR_SIZE-1:0] hi;
  } cfg_t;

  state_t              state_q, state_d;
  cfg_t                cfg_q, cfg_d;
  logic [ADR_SIZE-1:0] index_q, index_d;
  logic                phase_q, phase_d;
  logic [ADR_SIZE-1:0] adress_q, adress_d;
  logic                c_out_q, c_out_d;
  logic                err_q, err_d;
  logic                pass_req_c;
  logic [ADR_SIZE-1:0] term_q_c, term_d_c;

  // Index/phase to memory address mapping for the selected walk order.
  function automatic logic [ADR_SIZE-1:0] map_adr(
    input logic [ADR_SIZE-1:0] idx,
    input logic                ph,
    input logic [1:0]          md
  );
    logic [ADR_SIZE-1:0] res;
    unique case (md)
      MODE_COL: res = {idx[ROW_BITS-1:0], idx[ADR_SIZE-1:ROW_BITS]};
      MODE_CMP: res = ph ? ~idx : idx;
      default:  res = idx;
    endcase
    return res;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst_adr) begin
      state_q  <= S_IDLE;
      cfg_q    <= '0;
      index_q  <= '0;
      phase_q  <= 1'b0;
      adress_q <= '0;
      c_out_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      index_q  <= index_d;
      phase_q  <= phase_d;
      adress_q <= adress_d;
      c_out_q  <= c_out_d;
      err_q    <= err_d;
    end
  end

  // Next state: preset/start opens a pass, enable advances it; outputs follow.
  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    index_d    = index_q;
    phase_d    = phase_q;
    err_d      = 1'b0;
    term_q_c   = cfg_q.up_down ? cfg_q.hi : cfg_q.lo;
    pass_req_c = bus.pr_res_adr || (bus.start && (state_q != S_RUN));

    if (pass_req_c) begin
      if (bus.adr_lo > bus.adr_hi) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        cfg_d.up_down = bus.up_down;
        cfg_d.mode    = (bus.mode == MODE_RSV) ? MODE_LIN : bus.mode;
        cfg_d.lo      = bus.adr_lo;
        cfg_d.hi      = bus.adr_hi;
        index_d       = bus.up_down ? bus.adr_lo : bus.adr_hi;
        phase_d       = 1'b0;
        state_d       = S_RUN;
      end
    end else if ((state_q == S_RUN) && bus.enable) begin
      if ((cfg_q.mode == MODE_CMP) && !phase_q) begin
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        if (index_q == term_q_c) begin
          state_d = S_DONE;
        end else if (cfg_q.up_down) begin
          index_d = index_q + ADR_SIZE'(1);
        end else begin
          index_d = index_q - ADR_SIZE'(1);
        end
      end
    end

    term_d_c = cfg_d.up_down ? cfg_d.hi : cfg_d.lo;
    adress_d = (state_d == S_RUN) ? map_adr(index_d, phase_d, cfg_d.mode) : adress_q;
    c_out_d  = (state_d == S_RUN) && (index_d == term_d_c) &&
               ((cfg_d.mode != MODE_CMP) || phase_d);
  end

  assign bus.adress = adress_q;
  assign bus.valid  = (state_q == S_RUN);
  assign bus.done   = (state_q == S_DONE);
  assign bus.c_out  = c_out_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_bist_addr_seq.sv
// Self-checking bench for bist_addr_seq against a sequence-list reference model.
module tb_bist_addr_seq;

  localparam int unsigned ADR_SIZE = 8;
  localparam int unsigned COL_BITS = 4;
  localparam int unsigned ROW_BITS = ADR_SIZE - COL_BITS;

  logic clk;
  logic rst_adr;

  bist_addr_seq_if #(.ADR_SIZE(ADR_SIZE)) bus ();

  bist_addr_seq #(.ADR_SIZE(ADR_SIZE), .COL_BITS(COL_BITS)) dut (
    .clk     (clk),
    .rst_adr (rst_adr),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Reference model: a pass is the full list of addresses it must emit.
  logic [7:0] m_seq[$];
  int         m_pos;
  bit         m_run;
  bit         m_done;
  bit         m_err;
  logic [7:0] m_adr;

  // Current stimulus configuration.
  logic       c_ud;
  logic [1:0] c_md;
  logic [7:0] c_lo;
  logic [7:0] c_hi;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic build_seq(input logic ud, input logic [1:0] md, input int lo, input int hi);
    int i;
    int a;
    m_seq.delete();
    for (int k = 0; k <= hi - lo; k++) begin
      i = ud ? lo + k : hi - k;
      case (md)
        2'b01: begin
          a = ((i << COL_BITS) | (i >> ROW_BITS)) & 255;
          m_seq.push_back(8'(a));
        end
        2'b10: begin
          m_seq.push_back(8'(i));
          m_seq.push_back(8'(255 - i));
        end
        default: m_seq.push_back(8'(i));
      endcase
    end
  endtask

  // One clock: drive inputs, advance the model for that edge, compare outputs.
  task automatic cyc(input logic r, input logic p, input logic s, input logic e);
    @(negedge clk);
    rst_adr        = r;
    bus.pr_res_adr = p;
    bus.start      = s;
    bus.enable     = e;
    bus.up_down    = c_ud;
    bus.mode       = c_md;
    bus.adr_lo     = c_lo;
    bus.adr_hi     = c_hi;
    @(posedge clk);
    if (r) begin
      m_run = 0; m_done = 0; m_err = 0; m_adr = 8'h00; m_pos = 0;
      m_seq.delete();
    end else begin
      m_err = 0;
      if (p || (s && !m_run)) begin
        if (c_lo > c_hi) begin
          m_err = 1; m_run = 0; m_done = 0;
        end else begin
          build_seq(c_ud, c_md, int'(c_lo), int'(c_hi));
          m_pos = 0; m_run = 1; m_done = 0; m_adr = m_seq[0];
        end
      end else if (m_run && e) begin
        if (m_pos == m_seq.size() - 1) begin
          m_run = 0; m_done = 1;
        end else begin
          m_pos++;
          m_adr = m_seq[m_pos];
        end
      end
    end
    #1;
    check_val("adress", 32'(bus.adress), 32'(m_adr));
    check_val("valid",  32'(bus.valid),  32'(m_run));
    check_val("done",   32'(bus.done),   32'(m_done));
    check_val("err",    32'(bus.err),    32'(m_err));
    check_val("c_out",  32'(bus.c_out),  32'(m_run && (m_pos == m_seq.size() - 1)));
  endtask

  task automatic set_cfg(input logic ud, input logic [1:0] md, input logic [7:0] lo, input logic [7:0] hi);
    c_ud = ud; c_md = md; c_lo = lo; c_hi = hi;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    m_run = 0; m_done = 0; m_err = 0; m_adr = 8'h00; m_pos = 0;
    rst_adr = 1'b1;
    bus.pr_res_adr = 1'b0; bus.start = 1'b0; bus.enable = 1'b0;
    set_cfg(1'b1, 2'b00, 8'h00, 8'hFF);

    // Linear ascending, full range
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 1);
    for (int k = 0; k < 258; k++) cyc(0, 0, 0, 1);

    // Descending window with enable gaps
    set_cfg(1'b0, 2'b00, 8'h10, 8'h13);
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 10; k++) cyc(0, 0, 0, (k % 2) == 0);

    // Column-major
    set_cfg(1'b1, 2'b01, 8'h00, 8'h03);
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 1);

    // Address-complement
    set_cfg(1'b1, 2'b10, 8'h05, 8'h06);
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 1);

    // Preset mid-pass reverses to a descending restart
    set_cfg(1'b1, 2'b00, 8'h00, 8'h0F);
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 20 && m_adr != 8'h07; k++) cyc(0, 0, 0, 1);
    check_val("at_0x07", 32'(bus.adress), 32'h07);
    set_cfg(1'b0, 2'b00, 8'h00, 8'h0F);
    cyc(0, 1, 0, 1);
    check_val("preset_first", 32'(bus.adress), 32'h0F);
    for (int k = 0; k < 17; k++) cyc(0, 0, 0, 1);

    // Reset mid-pass
    set_cfg(1'b1, 2'b00, 8'h00, 8'h0F);
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 20 && m_adr != 8'h03; k++) cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    check_val("rst_valid", 32'(bus.valid), 32'h0);
    cyc(0, 0, 0, 1);

    // Bounds error, then single-address window
    set_cfg(1'b1, 2'b00, 8'h20, 8'h1F);
    cyc(0, 0, 1, 0);
    check_val("err_pulse", 32'(bus.err), 32'h1);
    cyc(0, 0, 0, 1);
    set_cfg(1'b1, 2'b00, 8'h2A, 8'h2A);
    cyc(0, 0, 1, 0);
    check_val("single_c_out", 32'(bus.c_out), 32'h1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // Boundary windows at both ends of the address space
    set_cfg(1'b0, 2'b00, 8'h00, 8'h02);
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1);
    set_cfg(1'b1, 2'b10, 8'hFE, 8'hFF);
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 1);

    // Randomized passes with mid-pass input churn
    for (int n = 0; n < 4000; n++) begin
      logic [7:0] lo;
      logic [7:0] span;
      int         hi;
      int         roll;
      lo   = 8'($urandom_range(0, 255));
      span = 8'($urandom_range(0, 9));
      hi   = int'(lo) + int'(span);
      if (hi > 255) hi = 255;
      roll = int'($urandom_range(0, 99));
      if (roll < 5) set_cfg(1'($urandom), 2'($urandom), 8'(hi), lo);
      else          set_cfg(1'($urandom), 2'($urandom), lo, 8'(hi));
      cyc(roll == 99,
          roll >= 96 && roll < 99,
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
